// File: rtl/amstrad_mmu_cfg_writer_if.sv
// Request and I/O-bus bundle for the MMU configuration writer.
// The slave modport is the writer; the master modport is whoever drives it.
interface amstrad_mmu_cfg_writer_if;
   logic        start;
   logic        en_ram;
   logic        en_rom;
   logic [7:0]  ram_cfg;
   logic        ram_hi;
   logic [7:0]  rom_sel;
   logic        cpu_busack;
   logic        cpu_busreq;
   logic        io_WR;
   logic [15:0] A;
   logic [7:0]  D;
   logic        busy;
   logic        done;

   modport master (
      output start, en_ram, en_rom, ram_cfg,
      output ram_hi, rom_sel, cpu_busack,
      input  cpu_busreq, io_WR, A, D, busy, done
   );

   modport slave (
      input  start, en_ram, en_rom, ram_cfg,
      input  ram_hi, rom_sel, cpu_busack,
      output cpu_busreq, io_WR, A, D, busy, done
   );
endinterface

// File: rtl/amstrad_mmu_cfg_writer.sv
// Replays the PAL MMR write (7F/7Exx) and upper-ROM select (DFxx)
// into the MMU decode path after grabbing the bus from the Z80.
module amstrad_mmu_cfg_writer #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int CNT_W      = 4
) (
   input  logic                      CLK,
   input  logic                      reset,
   amstrad_mmu_cfg_writer_if.slave   bus
);

   typedef enum logic [3:0] {
      IDLE, REQ,
      RAM_S, RAM_W, RAM_H,
      ROM_S, ROM_W, ROM_H,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_ram_q, en_rom_q, hi_q;
   logic [7:0]       ram_d_q, rom_q;

   logic             accept;
   logic             timed;
   logic [CNT_W-1:0] lim;
   state_t           nxt;

   assign accept = (state_q == IDLE) && bus.start;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         en_ram_q <= 1'b0;
         en_rom_q <= 1'b0;
         hi_q     <= 1'b0;
         ram_d_q  <= 8'h00;
         rom_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            en_ram_q <= bus.en_ram;
            en_rom_q <= bus.en_rom;
            hi_q     <= bus.ram_hi;
            // Top two MMR bits are always driven high on the bus
            ram_d_q  <= bus.ram_cfg | 8'hC0;
            rom_q    <= bus.rom_sel;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      timed   = 1'b0;
      lim     = '0;
      nxt     = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start)
               state_d = (bus.en_ram | bus.en_rom) ? REQ : DONE;
         end
         REQ: begin
            if (bus.cpu_busack)
               state_d = en_ram_q ? RAM_S : ROM_S;
         end
         RAM_S: begin timed = 1'b1; lim = S_LAST; nxt = RAM_W; end
         RAM_W: begin timed = 1'b1; lim = W_LAST; nxt = RAM_H; end
         RAM_H: begin
            timed = 1'b1;
            lim   = H_LAST;
            nxt   = en_rom_q ? ROM_S : DONE;
         end
         ROM_S: begin timed = 1'b1; lim = S_LAST; nxt = ROM_W; end
         ROM_W: begin timed = 1'b1; lim = W_LAST; nxt = ROM_H; end
         ROM_H: begin timed = 1'b1; lim = H_LAST; nxt = DONE; end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (timed) begin
         if (cnt_q == lim) state_d = nxt;
         else              cnt_d   = cnt_q + 1'b1;
      end
   end

   logic        busreq_o, wr_o, busy_o, done_o;
   logic [15:0] a_o;
   logic [7:0]  d_o;

   always_comb begin
      busreq_o = 1'b0;
      wr_o     = 1'b0;
      a_o      = 16'h0000;
      d_o      = 8'h00;
      busy_o   = (state_q != IDLE);
      done_o   = (state_q == DONE);
      unique case (state_q)
         REQ: busreq_o = 1'b1;
         RAM_S, RAM_W, RAM_H: begin
            busreq_o = 1'b1;
            wr_o     = (state_q == RAM_W);
            a_o      = {7'b0111111, ~hi_q, 8'h00};
            d_o      = ram_d_q;
         end
         ROM_S, ROM_W, ROM_H: begin
            busreq_o = 1'b1;
            wr_o     = (state_q == ROM_W);
            a_o      = 16'hDF00;
            d_o      = rom_q;
         end
         default: ;
      endcase
   end

   assign bus.cpu_busreq = busreq_o;
   assign bus.io_WR      = wr_o;
   assign bus.A          = a_o;
   assign bus.D          = d_o;
   assign bus.busy       = busy_o;
   assign bus.done       = done_o;

endmodule

// File: tb/tb_amstrad_mmu_cfg_writer.sv
// Directed vector bench for the MMU configuration writer.
// Table rows cover the write combinations; corner cases are hand sequences.
module tb_amstrad_mmu_cfg_writer;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   amstrad_mmu_cfg_writer_if bus ();

   amstrad_mmu_cfg_writer dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        en_ram;
      logic        en_rom;
      logic [7:0]  cfg;
      logic        hi;
      logic [7:0]  rom;
      int          nwr;
      logic [15:0] a0;
      logic [7:0]  d0;
      logic [15:0] a1;
      logic [7:0]  d1;
      int          dcyc;
   } vec_t;

   vec_t vt[6];

   // bus protocol monitor
   logic        p_wr, p_ack, p_rst;
   logic [15:0] p_a;
   logic [7:0]  p_d;
   always @(negedge CLK) begin
      if (!reset && !p_rst) begin
         if (bus.io_WR) chk("wr_needs_ack", bus.cpu_busack, 1'b1);
         if (bus.io_WR && p_wr) begin
            chk("a_stable", bus.A, p_a);
            chk("d_stable", bus.D, p_d);
         end
         if (bus.cpu_busreq && p_ack && !bus.cpu_busack)
            chk("busack_drop", 1'b0, 1'b1);
      end
      p_wr  <= bus.io_WR;
      p_ack <= bus.cpu_busack;
      p_rst <= reset;
      p_a   <= bus.A;
      p_d   <= bus.D;
   end

   int          r_nwr, r_dcyc, r_dcnt;
   int          r_rise[2], r_wid[2];
   logic [15:0] r_a[2];
   logic [7:0]  r_d[2];
   logic        r_req1, r_reqd, r_busy_end;
   logic [15:0] tr_a[0:47];

   task automatic kick(input vec_t v);
      @(posedge CLK); #1;
      bus.en_ram  = v.en_ram;
      bus.en_rom  = v.en_rom;
      bus.ram_cfg = v.cfg;
      bus.ram_hi  = v.hi;
      bus.rom_sel = v.rom;
      bus.start   = 1'b1;
      @(posedge CLK); #1;
      bus.start   = 1'b0;
      bus.ram_cfg = ~v.cfg;
      bus.ram_hi  = ~v.hi;
      bus.rom_sel = ~v.rom;
      bus.en_ram  = ~v.en_ram;
      bus.en_rom  = ~v.en_rom;
   endtask

   task automatic run(input vec_t v, input int inj, input string tg);
      logic pw;
      r_nwr = 0; r_dcyc = -1; r_dcnt = 0;
      r_req1 = 1'bx; r_reqd = 1'bx; r_busy_end = 1'bx;
      pw = 1'b0;
      kick(v);
      for (int c = 1; c < 48; c++) begin
         @(negedge CLK);
         tr_a[c] = bus.A;
         if (c == 1) r_req1 = bus.cpu_busreq;
         if (bus.io_WR && !pw) begin
            if (r_nwr < 2) begin
               r_rise[r_nwr] = c;
               r_a[r_nwr] = bus.A;
               r_d[r_nwr] = bus.D;
            end
            r_nwr++;
         end
         if (!bus.io_WR && pw && r_nwr <= 2)
            r_wid[r_nwr-1] = c - r_rise[r_nwr-1];
         pw = bus.io_WR;
         if (bus.done) begin
            r_dcnt++;
            if (r_dcyc < 0) begin
               r_dcyc = c;
               r_reqd = bus.cpu_busreq;
            end
         end
         if (c == inj) begin
            bus.start = 1'b1;
            bus.rom_sel = 8'hAA;
         end
         if (c == inj + 1) bus.start = 1'b0;
         if (r_dcyc > 0 && c >= r_dcyc + 3) begin
            r_busy_end = bus.busy;
            break;
         end
      end
      chk({tg, "_nwr"}, r_nwr, v.nwr);
      for (int k = 0; k < v.nwr && k < r_nwr && k < 2; k++) begin
         chk({tg, "_A"}, r_a[k], k == 0 ? v.a0 : v.a1);
         chk({tg, "_D"}, r_d[k], k == 0 ? v.d0 : v.d1);
         chk({tg, "_rise"}, r_rise[k], 4 + 8 * k);
         chk({tg, "_width"}, r_wid[k], 4);
         chk({tg, "_setupA"}, tr_a[r_rise[k] - 2], r_a[k]);
         chk({tg, "_holdA"}, tr_a[r_rise[k] + 5], r_a[k]);
      end
      chk({tg, "_done_cyc"}, r_dcyc, v.dcyc);
      chk({tg, "_done_cnt"}, r_dcnt, 1);
      chk({tg, "_req_T1"}, r_req1, v.en_ram | v.en_rom);
      chk({tg, "_req_done"}, r_reqd, 1'b0);
      chk({tg, "_busy_end"}, r_busy_end, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 1'b1, 8'hC4, 1'b0, 8'h07, 2,
                16'h7F00, 8'hC4, 16'hDF00, 8'h07, 18};
      vt[1] = '{1'b1, 1'b0, 8'h3F, 1'b1, 8'h11, 1,
                16'h7E00, 8'hFF, 16'h0000, 8'h00, 10};
      vt[2] = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h55, 1,
                16'hDF00, 8'h55, 16'h0000, 8'h00, 10};
      vt[3] = '{1'b0, 1'b0, 8'h12, 1'b1, 8'h55, 0,
                16'h0000, 8'h00, 16'h0000, 8'h00, 1};
      vt[4] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h80, 2,
                16'h7E00, 8'hFF, 16'hDF00, 8'h80, 18};
      vt[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1,
                16'h7F00, 8'hC0, 16'h0000, 8'h00, 10};

      reset = 1'b1;
      bus.start = 1'b0; bus.en_ram = 1'b0; bus.en_rom = 1'b0;
      bus.ram_cfg = 8'h00; bus.ram_hi = 1'b0; bus.rom_sel = 8'h00;
      bus.cpu_busack = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_busreq", bus.cpu_busreq, 1'b0);
      chk("rst_wr", bus.io_WR, 1'b0);
      chk("rst_A", bus.A, 16'h0000);
      chk("rst_D", bus.D, 8'h00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      @(posedge CLK); #1 reset = 1'b0;

      for (int i = 0; i < 6; i++)
         run(vt[i], 0, $sformatf("vec%0d", i));

      // bus grant delayed by 20 cycles
      @(posedge CLK); #1 bus.cpu_busack = 1'b0;
      kick(vt[5]);
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (c == 1 || c == 10 || c == 20) begin
            chk("ack0_busreq", bus.cpu_busreq, 1'b1);
            chk("ack0_wr", bus.io_WR, 1'b0);
            chk("ack0_A", bus.A, 16'h0000);
         end
      end
      bus.cpu_busack = 1'b1;
      begin
         int rise, dc;
         rise = -1; dc = -1;
         for (int c = 21; c < 60; c++) begin
            @(negedge CLK);
            if (c == 21) chk("ack1_A", bus.A, 16'h7F00);
            if (bus.io_WR && rise < 0) rise = c;
            if (bus.done) begin dc = c; break; end
         end
         chk("ack1_rise", rise, 23);
         chk("ack1_done", dc, 29);
      end

      // reset while the RAM strobe is high
      kick(vt[0]);
      for (int c = 1; c <= 5; c++) @(negedge CLK);
      chk("mid_wr_before", bus.io_WR, 1'b1);
      reset = 1'b1;
      @(negedge CLK);
      chk("mid_wr", bus.io_WR, 1'b0);
      chk("mid_busreq", bus.cpu_busreq, 1'b0);
      chk("mid_busy", bus.busy, 1'b0);
      chk("mid_A", bus.A, 16'h0000);
      chk("mid_D", bus.D, 8'h00);
      @(posedge CLK); #1 reset = 1'b0;
      run(vt[0], 0, "after_rst");

      // second start during ROM_S must be ignored
      run(vt[0], 10, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
